// File: rtl/tx_ordered_set_mux.sv
// Transmit symbol source: arbitrates packet bytes, LTSSM ordered sets (TS1/TS2/EIOS)
// and scheduled SKP sets onto a one-symbol-per-clock stream for the lane controller.
module tx_ordered_set_mux #(
    parameter int SKP_INTERVAL = 1180,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] pkt_data_i,
    input  logic                  pkt_k_i,
    input  logic                  pkt_valid_i,
    input  logic                  pkt_last_i,
    output logic                  pkt_ready_o,
    input  logic [1:0]            os_req_i,
    input  logic [7:0]            link_num_i,
    input  logic [7:0]            n_fts_i,
    input  logic [7:0]            rate_id_i,
    input  logic                  skp_en_i,
    output logic                  os_done_o,
    output logic                  skp_pending_o,
    output logic [DATA_WIDTH-1:0] data_frame_o,
    output logic                  data_frame_valid_o,
    output logic                  is_k_o,
    output logic                  is_ordered_set_o,
    output logic                  bypass_scrambler_o
);
    localparam int CNT_W = $clog2(SKP_INTERVAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PKT,
        S_TS,
        S_SKP,
        S_EIOS
    } state_t;

    state_t           state;
    state_t           next_unit;
    logic [3:0]       idx;
    logic             ts2;
    logic [CNT_W-1:0] skp_cnt;
    logic [1:0]       skp_owed;
    logic             skp_wrap;
    logic             skp_done;
    logic             os_end;
    logic             owe_skp;
    logic             accept;

    function automatic state_t pick_unit(input logic owe, input logic [1:0] req);
        state_t nxt;
        if (owe)                nxt = S_SKP;
        else if (req == 2'b11)  nxt = S_EIOS;
        else if (req != 2'b00)  nxt = S_TS;
        else                    nxt = S_IDLE;
        return nxt;
    endfunction

    // Returns {is_k, symbol} for ordered-set position i.
    function automatic logic [8:0] os_symbol(input state_t st, input logic is_ts2,
                                             input logic [3:0] i, input logic [7:0] link,
                                             input logic [7:0] nfts, input logic [7:0] rate);
        logic [8:0] sym;
        if (i == 4'd0) begin
            sym = {1'b1, 8'hBC};
        end else if (st == S_SKP) begin
            sym = {1'b1, 8'h1C};
        end else if (st == S_EIOS) begin
            sym = {1'b1, 8'h7C};
        end else begin
            case (i)
                4'd1:    sym = {1'b0, link};
                4'd2:    sym = {1'b1, 8'hF7};
                4'd3:    sym = {1'b0, nfts};
                4'd4:    sym = {1'b0, rate};
                4'd5:    sym = {1'b0, 8'h00};
                default: sym = {1'b0, is_ts2 ? 8'h45 : 8'h4A};
            endcase
        end
        return sym;
    endfunction

    assign skp_wrap  = (skp_cnt == CNT_W'(SKP_INTERVAL - 1));
    assign skp_done  = (state == S_SKP) && (idx == 4'd3);
    assign os_end    = (state == S_TS) ? (idx == 4'd15) : (idx == 4'd3);
    // The SKP set finishing this cycle already pays off one owed SKP.
    assign owe_skp   = skp_done ? (skp_owed >= 2'd2) : (skp_owed != 2'd0);
    assign next_unit = pick_unit(owe_skp, os_req_i);

    assign pkt_ready_o = rst_i && ((state == S_PKT) ||
                         ((state == S_IDLE) && (skp_owed == 2'd0) && (os_req_i == 2'b00)));
    assign accept      = pkt_valid_i && pkt_ready_o;

    assign skp_pending_o      = (skp_owed != 2'd0);
    assign bypass_scrambler_o = is_ordered_set_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state              <= S_IDLE;
            idx                <= 4'd0;
            ts2                <= 1'b0;
            data_frame_o       <= '0;
            data_frame_valid_o <= 1'b0;
            is_k_o             <= 1'b0;
            is_ordered_set_o   <= 1'b0;
            os_done_o          <= 1'b0;
        end else begin
            data_frame_o       <= '0;
            data_frame_valid_o <= 1'b0;
            is_k_o             <= 1'b0;
            is_ordered_set_o   <= 1'b0;
            os_done_o          <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (next_unit != S_IDLE) begin
                        state <= next_unit;
                        ts2   <= (os_req_i == 2'b10);
                        idx   <= 4'd0;
                    end else if (accept) begin
                        data_frame_o       <= pkt_data_i;
                        data_frame_valid_o <= 1'b1;
                        is_k_o             <= pkt_k_i;
                        if (!pkt_last_i) state <= S_PKT;
                    end
                end
                S_PKT: begin
                    if (pkt_valid_i) begin
                        data_frame_o       <= pkt_data_i;
                        data_frame_valid_o <= 1'b1;
                        is_k_o             <= pkt_k_i;
                        if (pkt_last_i) begin
                            state <= next_unit;
                            ts2   <= (os_req_i == 2'b10);
                            idx   <= 4'd0;
                        end
                    end
                end
                default: begin
                    {is_k_o, data_frame_o} <= os_symbol(state, ts2, idx, link_num_i,
                                                        n_fts_i, rate_id_i);
                    data_frame_valid_o <= 1'b1;
                    is_ordered_set_o   <= 1'b1;
                    if (os_end) begin
                        os_done_o <= (state != S_SKP);
                        state     <= next_unit;
                        ts2       <= (os_req_i == 2'b10);
                        idx       <= 4'd0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
            endcase
        end
    end

    // SKP scheduler: a wrap owes one more SKP (max 3); a finished SKP set pays one back.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skp_cnt  <= '0;
            skp_owed <= 2'd0;
        end else if (!skp_en_i) begin
            skp_cnt  <= '0;
            skp_owed <= 2'd0;
        end else begin
            skp_cnt <= skp_wrap ? '0 : skp_cnt + CNT_W'(1);
            if (skp_wrap && !skp_done && (skp_owed != 2'd3))
                skp_owed <= skp_owed + 2'd1;
            else if (skp_done && !skp_wrap && (skp_owed != 2'd0))
                skp_owed <= skp_owed - 2'd1;
        end
    end

endmodule

// File: tb/tb_tx_ordered_set_mux.sv
// Bench for tx_ordered_set_mux: vector table, directed corner sequences and
// randomized traffic against a unit-level queue model.
module tb_tx_ordered_set_mux;
    localparam int INTERVAL = 64;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] pkt_data;
    logic       pkt_k, pkt_valid, pkt_last;
    logic       pkt_ready;
    logic [1:0] os_req;
    logic [7:0] link_num, n_fts, rate_id;
    logic       skp_en;
    logic       os_done, skp_pending;
    logic [7:0] data_frame;
    logic       frame_valid, is_k, is_os, bypass;

    always #5 clk = ~clk;

    tx_ordered_set_mux #(.SKP_INTERVAL(INTERVAL), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pkt_data_i(pkt_data), .pkt_k_i(pkt_k), .pkt_valid_i(pkt_valid),
        .pkt_last_i(pkt_last), .pkt_ready_o(pkt_ready),
        .os_req_i(os_req), .link_num_i(link_num), .n_fts_i(n_fts), .rate_id_i(rate_id),
        .skp_en_i(skp_en), .os_done_o(os_done), .skp_pending_o(skp_pending),
        .data_frame_o(data_frame), .data_frame_valid_o(frame_valid), .is_k_o(is_k),
        .is_ordered_set_o(is_os), .bypass_scrambler_o(bypass)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, want %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of pending ordered-set symbols ----------------
    typedef struct { int kind; int idx; } sym_t;   // kind 0 SKP, 1 TS1, 2 TS2, 3 EIOS
    sym_t q[$];
    bit   in_pkt;
    int   owed, ticks;
    logic m_vld, m_k, m_os, m_done, m_pend;
    logic [7:0] m_dat;

    function automatic logic [8:0] os_value(input int kind, input int i);
        if (i == 0) return {1'b1, 8'hBC};
        if (kind == 0) return {1'b1, 8'h1C};
        if (kind == 3) return {1'b1, 8'h7C};
        case (i)
            1: return {1'b0, link_num};
            2: return {1'b1, 8'hF7};
            3: return {1'b0, n_fts};
            4: return {1'b0, rate_id};
            5: return {1'b0, 8'h00};
            default: return {1'b0, (kind == 1) ? 8'h4A : 8'h45};
        endcase
    endfunction

    function automatic void load(input int kind);
        int n = (kind == 1 || kind == 2) ? 16 : 4;
        for (int i = 0; i < n; i++) q.push_back('{kind, i});
    endfunction

    function automatic void arbitrate();
        if (owed > 0) load(0);
        else if (os_req != 2'b00) load(int'(os_req));
    endfunction

    function automatic logic model_ready();
        if (q.size() > 0) return 1'b0;
        if (in_pkt) return 1'b1;
        return (owed == 0) && (os_req == 2'b00);
    endfunction

    function automatic void model_reset();
        q.delete();
        in_pkt = 0; owed = 0; ticks = 0;
    endfunction

    function automatic void emit_byte();
        m_vld = 1'b1; m_dat = pkt_data; m_k = pkt_k;
    endfunction

    function automatic void model_edge();
        bit   end_unit = 0, fin_skp = 0;
        sym_t s;
        logic [8:0] v;
        m_vld = 0; m_dat = 8'h00; m_k = 0; m_os = 0; m_done = 0;
        if (q.size() > 0) begin
            s = q.pop_front();
            v = os_value(s.kind, s.idx);
            m_vld = 1'b1; m_os = 1'b1; m_k = v[8]; m_dat = v[7:0];
            if (q.size() == 0) begin
                end_unit = 1;
                if (s.kind == 0) fin_skp = 1; else m_done = 1'b1;
            end
        end else if (in_pkt) begin
            if (pkt_valid) begin
                emit_byte();
                if (pkt_last) begin in_pkt = 0; end_unit = 1; end
            end
        end else if (owed > 0 || os_req != 2'b00) begin
            arbitrate();
        end else if (pkt_valid) begin
            emit_byte();
            if (!pkt_last) in_pkt = 1;
        end
        if (fin_skp && owed > 0) owed--;
        if (end_unit) arbitrate();
        if (!skp_en) begin
            ticks = 0; owed = 0;
        end else begin
            ticks++;
            if (ticks == INTERVAL) begin
                ticks = 0;
                if (owed < 3) owed++;
            end
        end
        m_pend = (owed > 0);
    endfunction

    // ---------------- history of observed outputs for directed checks ----------------
    logic [7:0] h_dat [0:511];
    logic       h_vld [0:511];
    logic       h_os  [0:511];
    logic       h_done[0:511];
    logic       h_pend[0:511];
    logic       h_rdy [0:511];
    int         hn;

    task automatic cyc(input string tag);
        logic r;
        #1;
        r = model_ready();
        chk1({tag, " ready"}, pkt_ready, r);
        if (hn < 512) h_rdy[hn] = pkt_ready;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk1({tag, " valid"}, frame_valid, m_vld);
        if (m_vld) begin
            chk8({tag, " data"}, data_frame, m_dat);
            chk1({tag, " is_k"}, is_k, m_k);
            chk1({tag, " is_os"}, is_os, m_os);
            chk1({tag, " bypass"}, bypass, m_os);
        end
        chk1({tag, " os_done"}, os_done, m_done);
        chk1({tag, " skp_pending"}, skp_pending, m_pend);
        if (hn < 512) begin
            h_dat[hn] = data_frame; h_vld[hn] = frame_valid; h_os[hn] = is_os;
            h_done[hn] = os_done; h_pend[hn] = skp_pending;
            hn++;
        end
    endtask

    task automatic do_reset(input logic en);
        #2;
        rst_i = 1'b0;
        #1;
        chk1("reset valid", frame_valid, 1'b0);
        chk8("reset data", data_frame, 8'h00);
        chk1("reset is_k", is_k, 1'b0);
        chk1("reset is_os", is_os, 1'b0);
        chk1("reset bypass", bypass, 1'b0);
        chk1("reset os_done", os_done, 1'b0);
        chk1("reset skp_pending", skp_pending, 1'b0);
        chk1("reset ready", pkt_ready, 1'b0);
        skp_en = en;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        model_reset();
        hn = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic vld; logic [7:0] dat; logic k; logic last; logic [1:0] req;
        logic e_rdy; logic e_vld; logic [7:0] e_dat; logic e_k; logic e_os; logic e_done;
    } vec_t;

    function automatic vec_t mkv(input bit v, input logic [7:0] d, input bit k, input bit l,
                                 input logic [1:0] r, input bit er, input bit ev,
                                 input logic [7:0] ed, input bit ek, input bit eo, input bit edn);
        vec_t t;
        t.vld = v; t.dat = d; t.k = k; t.last = l; t.req = r;
        t.e_rdy = er; t.e_vld = ev; t.e_dat = ed; t.e_k = ek; t.e_os = eo; t.e_done = edn;
        return t;
    endfunction

    vec_t tbl[12];
    int   cnt, skp_between;
    bit   any_rdy;
    int   hold, off;

    initial begin
        rst_i = 1'b0; pkt_data = 8'h00; pkt_k = 0; pkt_valid = 0; pkt_last = 0;
        os_req = 2'b00; link_num = 8'h05; n_fts = 8'h20; rate_id = 8'h02; skp_en = 0;
        hn = 0;
        @(negedge clk);

        // Packet FB,01,02,FD back to back, then EIOS with a mid-set request change.
        tbl[0]  = mkv(H, 8'hFB, H, L, 2'b00,  H, H, 8'hFB, H, L, L);
        tbl[1]  = mkv(H, 8'h01, L, L, 2'b00,  H, H, 8'h01, L, L, L);
        tbl[2]  = mkv(H, 8'h02, L, L, 2'b00,  H, H, 8'h02, L, L, L);
        tbl[3]  = mkv(H, 8'hFD, H, H, 2'b00,  H, H, 8'hFD, H, L, L);
        tbl[4]  = mkv(L, 8'h00, L, L, 2'b00,  H, L, 8'h00, L, L, L);
        tbl[5]  = mkv(H, 8'h55, L, L, 2'b11,  L, L, 8'h00, L, L, L);
        tbl[6]  = mkv(H, 8'h55, L, L, 2'b01,  L, H, 8'hBC, H, H, L);
        tbl[7]  = mkv(H, 8'h55, L, L, 2'b01,  L, H, 8'h7C, H, H, L);
        tbl[8]  = mkv(H, 8'h55, L, L, 2'b01,  L, H, 8'h7C, H, H, L);
        tbl[9]  = mkv(L, 8'h55, L, L, 2'b00,  L, H, 8'h7C, H, H, H);
        tbl[10] = mkv(H, 8'h33, L, H, 2'b00,  H, H, 8'h33, L, L, L);
        tbl[11] = mkv(L, 8'h00, L, L, 2'b00,  H, L, 8'h00, L, L, L);

        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            pkt_valid = tbl[i].vld; pkt_data = tbl[i].dat; pkt_k = tbl[i].k;
            pkt_last = tbl[i].last; os_req = tbl[i].req;
            #1;
            chk1($sformatf("tbl%0d ready", i), pkt_ready, tbl[i].e_rdy);
            @(posedge clk);
            @(negedge clk);
            chk1($sformatf("tbl%0d valid", i), frame_valid, tbl[i].e_vld);
            chk1($sformatf("tbl%0d os_done", i), os_done, tbl[i].e_done);
            if (tbl[i].e_vld) begin
                chk8($sformatf("tbl%0d data", i), data_frame, tbl[i].e_dat);
                chk1($sformatf("tbl%0d is_k", i), is_k, tbl[i].e_k);
                chk1($sformatf("tbl%0d is_os", i), is_os, tbl[i].e_os);
                chk1($sformatf("tbl%0d bypass", i), bypass, tbl[i].e_os);
            end
        end
        pkt_valid = 0; pkt_last = 0; os_req = 2'b00;

        // TS1 held for 32 symbol clocks: two back-to-back sets.
        do_reset(1'b0);
        link_num = 8'h05; n_fts = 8'h20; rate_id = 8'h02;
        for (int c = 0; c < 34; c++) begin
            os_req = (c < 32) ? 2'b01 : 2'b00;
            cyc("ts1");
        end
        any_rdy = 0; cnt = 0;
        for (int i = 0; i < 33; i++) begin
            any_rdy |= h_rdy[i];
            if (h_done[i]) cnt++;
        end
        chk1("ts1 ready never", any_rdy, 1'b0);
        chk8("ts1 done count", 8'(cnt), 8'd2);
        chk1("ts1 done at 16", h_done[16], 1'b1);
        chk1("ts1 done at 32", h_done[32], 1'b1);
        chk8("ts1 second set COM", h_dat[17], 8'hBC);
        chk8("ts1 id symbol", h_dat[7], 8'h4A);
        chk1("ts1 idle after", h_vld[33], 1'b0);

        // SKP deferred by a 100-byte packet.
        do_reset(1'b1);
        for (int c = 0; c < 120; c++) begin
            pkt_valid = (c >= 10 && c < 110);
            pkt_data  = 8'(c - 10);
            pkt_k     = (c == 10 || c == 109);
            pkt_last  = (c == 109);
            cyc("skpdef");
        end
        pkt_valid = 0; pkt_last = 0; pkt_k = 0;
        chk1("skpdef pending before", h_pend[62], 1'b0);
        chk1("skpdef pending at 64", h_pend[63], 1'b1);
        chk8("skpdef last byte", h_dat[109], 8'd99);
        chk8("skpdef COM", h_dat[110], 8'hBC);
        chk1("skpdef COM is_os", h_os[110], 1'b1);
        chk8("skpdef SKP sym", h_dat[113], 8'h1C);
        chk1("skpdef cleared", h_pend[113], 1'b0);
        chk1("skpdef idle after", h_vld[114], 1'b0);

        // Mid-packet stall with EIOS pending.
        do_reset(1'b0);
        pkt_valid = 1; pkt_data = 8'hA0; pkt_k = 1; pkt_last = 0; os_req = 2'b00; cyc("stall");
        pkt_data = 8'hA1; pkt_k = 0; os_req = 2'b11; cyc("stall");
        pkt_valid = 0; repeat (3) cyc("stall");
        pkt_valid = 1; pkt_data = 8'hA2; cyc("stall");
        pkt_data = 8'hA3; cyc("stall");
        pkt_data = 8'hA4; pkt_k = 1; pkt_last = 1; cyc("stall");
        pkt_valid = 0; pkt_last = 0; pkt_k = 0; repeat (3) cyc("stall");
        os_req = 2'b00; repeat (2) cyc("stall");
        chk1("stall gap0", h_vld[2], 1'b0);
        chk1("stall gap1", h_vld[3], 1'b0);
        chk1("stall gap2", h_vld[4], 1'b0);
        chk8("stall last byte", h_dat[7], 8'hA4);
        chk8("stall EIOS COM", h_dat[8], 8'hBC);
        chk1("stall EIOS done", h_done[11], 1'b1);

        // SKP saturation behind a long packet: exactly three SKP sets afterwards.
        do_reset(1'b1);
        for (int c = 0; c < 320; c++) begin
            pkt_valid = (c < 300);
            pkt_data  = 8'($urandom);
            pkt_k     = 0;
            pkt_last  = (c == 299);
            cyc("sat");
        end
        pkt_valid = 0; pkt_last = 0;
        cnt = 0;
        for (int i = 300; i < 316; i++) if (h_vld[i] && h_os[i] && h_dat[i] == 8'h1C) cnt++;
        chk8("sat SKP symbol count", 8'(cnt), 8'd9);
        chk1("sat pending drained", h_pend[311], 1'b0);

        // Held TS2 with SKP inserted between sets.
        do_reset(1'b1);
        os_req = 2'b10;
        repeat (240) cyc("ts2skp");
        cnt = 0; skp_between = 0;
        for (int i = 1; i < 239; i++) begin
            if (h_os[i] && h_dat[i] == 8'h1C) cnt++;
            if (h_dat[i] == 8'hBC && h_dat[i+1] == 8'h1C && h_done[i-1]) skp_between++;
        end
        chk8("ts2skp SKP symbols", 8'(cnt), 8'd9);
        chk8("ts2skp SKP after TS2", 8'(skp_between), 8'd3);

        // Reset in the middle of a TS2 set.
        do_reset(1'b0);
        os_req = 2'b10;
        repeat (9) cyc("rst_ts2");
        chk8("rst_ts2 sym7", h_dat[8], 8'h45);
        do_reset(1'b0);
        repeat (18) cyc("rst_ts2b");
        chk1("rst_ts2 idle first", h_vld[0], 1'b0);
        chk8("rst_ts2 restart COM", h_dat[1], 8'hBC);
        chk1("rst_ts2 no early done", h_done[15], 1'b0);
        chk1("rst_ts2 done at 16", h_done[16], 1'b1);
        os_req = 2'b00;

        // Randomized traffic against the model.
        do_reset(1'b1);
        hold = 0; off = 0;
        for (int c = 0; c < 3000; c++) begin
            pkt_valid = ($urandom_range(0, 9) < 7);
            pkt_data  = 8'($urandom);
            pkt_k     = ($urandom_range(0, 7) == 0);
            pkt_last  = ($urandom_range(0, 5) == 0);
            link_num  = 8'($urandom);
            n_fts     = 8'($urandom);
            rate_id   = 8'($urandom);
            if (hold > 0) begin
                hold--;
            end else begin
                os_req = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if (os_req != 2'b00) hold = $urandom_range(0, 40);
            end
            if (off > 0) begin
                off--;
                skp_en = (off == 0);
            end else if ($urandom_range(0, 499) == 0) begin
                off = $urandom_range(1, 5);
                skp_en = 0;
            end
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_ordered_set_mux.md
# tx_ordered_set_mux

Transmit symbol-stream source that sits directly upstream of the multi-lane TX controller and drives its `data_frame_i`, `data_frame_valid_i`, `is_ordered_set_i` and `bypass_scrambler_i` inputs. It arbitrates between three sources:

- TLP/DLLP bytes from the data link layer (valid/ready stream),
- LTSSM-requested ordered sets (TS1, TS2, EIOS),
- periodically scheduled SKP ordered sets.

Switching happens only on packet and ordered-set boundaries. Output is one symbol per clock.

## Interface
Parameters:
- `SKP_INTERVAL`, 1180 — symbol clocks between SKP schedule events; legal range ≥ 32.
- `DATA_WIDTH`, 8 — symbol width; only 8 is supported.

Ports:
- `clk_i` input 1 — symbol clock.
- `rst_i` input 1 — asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `pkt_data_i` input 8 — packet byte.
- `pkt_k_i` input 1 — byte is a K symbol (framing, e.g. STP/SDP/END).
- `pkt_valid_i` input 1 — packet byte valid.
- `pkt_last_i` input 1 — final byte of the packet.
- `pkt_ready_o` output 1 — byte accepted when `pkt_valid_i & pkt_ready_o`.
- `os_req_i` input 2 — ordered-set request level: 00 none, 01 TS1, 10 TS2, 11 EIOS.
- `link_num_i` input 8 — TS symbol 1.
- `n_fts_i` input 8 — TS symbol 3.
- `rate_id_i` input 8 — TS symbol 4.
- `skp_en_i` input 1 — enables SKP scheduling.
- `os_done_o` output 1 — one-cycle pulse on the cycle the last TS/EIOS symbol appears on `data_frame_o`.
- `skp_pending_o` output 1 — at least one SKP is owed.
- `data_frame_o` output 8 — symbol to the lane controller.
- `data_frame_valid_o` output 1 — `data_frame_o` valid.
- `is_k_o` output 1 — symbol is a K code.
- `is_ordered_set_o` output 1 — symbol belongs to an ordered set.
- `bypass_scrambler_o` output 1 — equals `is_ordered_set_o`.

## Operation
Ordered-set contents, by symbol index:
- **TS1/TS2 (16 symbols):**
  - 0: COM K28.5 (0xBC, K)
  - 1: `link_num_i`
  - 2: PAD K23.7 (0xF7, K)
  - 3: `n_fts_i`
  - 4: `rate_id_i`
  - 5: 0x00
  - 6–15: 0x4A for TS1, 0x45 for TS2
- **SKP (4 symbols):** 0xBC, then 0x1C ×3. All K.
- **EIOS (4 symbols):** 0xBC, then 0x7C ×3. All K.
- TS fields are sampled on every emitted symbol, not latched.

States are IDLE, PKT, TS, SKP, EIOS. A 4-bit index counts ordered-set symbols.

Arbitration runs in IDLE and on the cycle a unit ends (last OS symbol emitted, or last packet byte accepted). Priority order:
1. `skp_pending_o` → SKP.
2. `os_req_i` 01/10 → TS; 11 → EIOS.
3. Otherwise → IDLE.

Per-state behaviour:
- **IDLE:**
  - `pkt_ready_o = !skp_pending_o && os_req_i == 0`.
  - An accepted non-last byte moves to PKT; an accepted last byte stays in IDLE, so back-to-back packets have no bubble.
  - If SKP or an OS wins, move to that state and emit nothing this cycle.
- **PKT:**
  - `pkt_ready_o = 1`.
  - If `pkt_valid_i` is low, emit nothing (`data_frame_valid_o = 0`) and stay in PKT.
  - No ordered set may interrupt a packet.
- **TS/SKP/EIOS:**
  - `pkt_ready_o = 0`.
  - Emit index 0..N−1 on consecutive cycles, then re-arbitrate.
  - A held `os_req_i` repeats the set with zero gap.
  - Changes to `os_req_i` mid-set are ignored until the set ends.

SKP scheduler:
- Counter width is `$clog2(SKP_INTERVAL)`. It increments every clock while `skp_en_i = 1` and wraps at `SKP_INTERVAL−1`.
- Each wrap increments a 2-bit pending count, saturating at 3.
- Completing an SKP set decrements the count. A wrap and a completion in the same cycle leave the count unchanged.
- `skp_en_i = 0` clears both the counter and the pending count next cycle. An SKP set already in progress still finishes.

Output flags:
- Packet bytes: `is_ordered_set_o = 0`, `bypass_scrambler_o = 0`, `is_k_o = pkt_k_i`.
- Ordered-set symbols: `is_ordered_set_o = 1`, `bypass_scrambler_o = 1`.

## Timing
- All outputs except `pkt_ready_o` are registered.
  - A byte accepted in cycle N appears on `data_frame_o` at N+1.
  - An OS state entered at cycle E drives symbol 0 at E+1 and symbol N−1 at E+N.
  - `os_done_o` is coincident with that last symbol.
- `pkt_ready_o` is a function of state, pending count and `os_req_i` only. It never depends on `pkt_valid_i`.
- When arbitration leaves IDLE for an OS or SKP, there is exactly one idle output cycle. Transitions at the end of a unit have no gap.
- Reset (`rst_i` low, asynchronous):
  - State is IDLE; counter, pending count and index are 0.
  - All outputs are 0, including `pkt_ready_o` while reset is asserted.
  - Reset asserted mid-set or mid-packet abandons it with no completion pulse.
  - The first SKP is owed `SKP_INTERVAL` clocks after release, provided `skp_en_i = 1`.

## Test plan
- **Packet with zero gap:** `SKP_INTERVAL = 64`, `skp_en_i = 0`; send packet 0xFB,0x01,0x02,0xFD (K on first/last) with `pkt_valid_i` held high → bytes appear on consecutive cycles at a latency of 1, flags 0, `is_k_o` 1,0,0,1.
- **TS1 repeat:** `os_req_i = 01`, `link_num_i = 0x05`, `n_fts_i = 0x20`, `rate_id_i = 0x02`, held for 32 clocks → two back-to-back sets BC,05,F7,20,02,00,4A×10; `os_done_o` pulses at output cycles 16 and 32; `pkt_ready_o = 0` throughout.
- **SKP deferred by packet:** `SKP_INTERVAL = 64`; start a 100-byte packet at cycle 10 → SKP pending at cycle 64; packet completes uninterrupted; BC,1C,1C,1C follows the last byte with no gap; pending clears.
- **SKP saturation:** `SKP_INTERVAL = 32`, `os_req_i` held at 10 for 200 clocks; since the held request keeps TS sets going, check that the pending count never exceeds 3, that SKP sets are inserted between TS2 sets, and that SKP wins over the held TS2.
- **Mid-packet stall:** drop `pkt_valid_i` for 3 cycles mid-packet → `data_frame_valid_o` low for 3 cycles; no ordered set is inserted even though `os_req_i = 11` is pending; EIOS follows the last byte.
- **Reset mid-TS2:** at symbol 7, assert `rst_i` low → all outputs 0 immediately; no `os_done_o`; after release, TS2 restarts at symbol 0.
